// File: rtl/memory_responder_pkg.sv
// Shared types for the memory responder: access modes used by the core and boot-load states.
package memory_responder_pkg;

   typedef enum logic [2:0] {
      BYTE  = 3'd0,
      HALF  = 3'd1,
      WORD  = 3'd2,
      UBYTE = 3'd3,
      UHALF = 3'd4
   } ldst_mode;

   typedef enum logic [0:0] {
      LOAD = 1'b0,
      RUN  = 1'b1
   } mem_state;

   // Alignment rule shared by the read lanes and the store path.
   function automatic logic is_misaligned(input ldst_mode mode, input logic [1:0] addr);
      logic bad;
      case (mode)
         HALF, UHALF: bad = addr[0];
         WORD:        bad = (addr != 2'b00);
         default:     bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/memory_responder_read_lane.sv
// One read lane: picks the byte/half/word out of a RAM word and sign- or zero-extends it.
module mem_read_lane
   import memory_responder_pkg::*;
(
   input  logic [1:0]  addr,
   input  ldst_mode    mode,
   input  logic [31:0] word,
   output logic [31:0] data,
   output logic        misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = addr[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      case (mode)
         BYTE:    data = {{24{byte_sel[7]}}, byte_sel};
         UBYTE:   data = {24'd0, byte_sel};
         HALF:    data = {{16{half_sel[15]}}, half_sel};
         UHALF:   data = {16'd0, half_sel};
         WORD:    data = word;
         default: data = 32'd0;
      endcase
      misaligned = is_misaligned(mode, addr);
   end

endmodule

// File: rtl/memory_responder.sv
// Unified instruction/data RAM: four combinational read ports, one byte-masked store port,
// and a boot loader that fills the RAM and holds the core stopped until the image is in.
module memory_responder
   import memory_responder_pkg::*;
#(
   parameter int DEPTH = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ra [4],
   input  ldst_mode    rm [4],
   output logic [31:0] rd [4],
   input  logic        we,
   input  logic [31:0] wa,
   input  logic [31:0] wd,
   input  ldst_mode    wm,
   input  logic        ld_valid,
   input  logic [31:0] ld_data,
   input  logic        ld_last,
   output logic        ld_ready,
   output logic        core_run,
   output logic        err,
   output logic [31:0] err_addr
);

   localparam int          AW    = $clog2(DEPTH);
   localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

   logic [31:0] mem [DEPTH];

   mem_state    state_reg, state_next;
   logic [AW:0] ptr_reg, ptr_next;
   logic        err_reg, err_next;
   logic [31:0] err_addr_reg, err_addr_next;

   logic [3:0]  rd_bad;

   // Read ports: out-of-range or misaligned reads, and any read while loading, return 0.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_read
         logic [31:0] lane_word;
         logic [31:0] lane_data;
         logic        lane_mis;

         assign lane_word = mem[ra[gi][AW+1:2]];

         mem_read_lane u_lane (
            .addr       (ra[gi][1:0]),
            .mode       (rm[gi]),
            .word       (lane_word),
            .data       (lane_data),
            .misaligned (lane_mis)
         );

         assign rd_bad[gi] = lane_mis || (ra[gi] >= LIMIT);
         assign rd[gi]     = (state_reg == RUN && !rd_bad[gi]) ? lane_data : 32'd0;
      end
   endgenerate

   logic        wr_bad;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;

   assign wr_bad = is_misaligned(wm, wa[1:0]) || (wa >= LIMIT);

   always_comb begin
      bus_be    = 4'b0000;
      bus_wdata = 32'd0;
      case (wm)
         BYTE, UBYTE: begin
            bus_be    = 4'b0001 << wa[1:0];
            bus_wdata = {4{wd[7:0]}};
         end
         HALF, UHALF: begin
            bus_be    = wa[1] ? 4'b1100 : 4'b0011;
            bus_wdata = {2{wd[15:0]}};
         end
         WORD: begin
            bus_be    = 4'b1111;
            bus_wdata = wd;
         end
         default: ;
      endcase
   end

   logic [3:0]    mem_be;
   logic [AW-1:0] mem_idx;
   logic [31:0]   mem_wdata;

   // The loader owns the RAM in LOAD, the bus store port in RUN; nothing writes on a reset edge.
   always_comb begin
      mem_be    = 4'b0000;
      mem_idx   = '0;
      mem_wdata = 32'd0;
      if (reset) begin
         if (state_reg == LOAD) begin
            if (ld_valid && !ptr_reg[AW]) begin
               mem_be    = 4'b1111;
               mem_idx   = ptr_reg[AW-1:0];
               mem_wdata = ld_data;
            end
         end else if (we && !wr_bad) begin
            mem_be    = bus_be;
            mem_idx   = wa[AW+1:2];
            mem_wdata = bus_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (mem_be[b]) begin
            mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   logic        hit;
   logic [31:0] hit_addr;

   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      err_next      = err_reg;
      err_addr_next = err_addr_reg;
      hit           = 1'b0;
      hit_addr      = 32'd0;
      if (state_reg == LOAD) begin
         if (ld_valid) begin
            if (ptr_reg[AW]) begin
               hit      = 1'b1;
               hit_addr = LIMIT;
            end else begin
               ptr_next = ptr_reg + 1'b1;
               if (ld_last) begin
                  state_next = RUN;
               end
            end
         end
      end else begin
         // Later assignments win: scan port 3 down to 0, then the store, giving store top priority.
         for (int i = 3; i >= 0; i--) begin
            if (rd_bad[i]) begin
               hit      = 1'b1;
               hit_addr = ra[i];
            end
         end
         if (we && wr_bad) begin
            hit      = 1'b1;
            hit_addr = wa;
         end
      end
      if (hit) begin
         err_next = 1'b1;
         if (!err_reg) begin
            err_addr_next = hit_addr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= LOAD;
         ptr_reg      <= '0;
         err_reg      <= 1'b0;
         err_addr_reg <= 32'd0;
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         err_reg      <= err_next;
         err_addr_reg <= err_addr_next;
      end
   end

   assign ld_ready = (state_reg == LOAD);
   assign core_run = (state_reg == RUN);
   assign err      = err_reg;
   assign err_addr = err_addr_reg;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: full-size instance for load/access tests, DEPTH=4 for overflow.
module tb_memory_responder;
   import memory_responder_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] ra [4];
   ldst_mode    rm [4];
   logic [31:0] rd [4];
   logic        we;
   logic [31:0] wa, wd;
   ldst_mode    wm;
   logic        ld_valid, ld_last;
   logic [31:0] ld_data;
   logic        ld_ready, core_run, err;
   logic [31:0] err_addr;

   logic        s_reset;
   logic [31:0] s_rd [4];
   logic        s_ld_valid, s_ld_last;
   logic [31:0] s_ld_data;
   logic        s_ld_ready, s_core_run, s_err;
   logic [31:0] s_err_addr;

   memory_responder #(.DEPTH(4096)) dut (
      .clk(clk), .reset(reset), .ra(ra), .rm(rm), .rd(rd),
      .we(we), .wa(wa), .wd(wd), .wm(wm),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
      .ld_ready(ld_ready), .core_run(core_run), .err(err), .err_addr(err_addr)
   );

   memory_responder #(.DEPTH(4)) dut_small (
      .clk(clk), .reset(s_reset), .ra(ra), .rm(rm), .rd(s_rd),
      .we(we), .wa(wa), .wd(wd), .wm(wm),
      .ld_valid(s_ld_valid), .ld_data(s_ld_data), .ld_last(s_ld_last),
      .ld_ready(s_ld_ready), .core_run(s_core_run), .err(s_err), .err_addr(s_err_addr)
   );

   typedef struct {
      string       name;
      int          port;
      logic [31:0] exp;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks   = 0;
   int   failures = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_read(input string name, input int port, input logic [31:0] addr,
                             input ldst_mode mode, input logic [31:0] exp);
      exp_t x;
      ra[port] = addr;
      rm[port] = mode;
      x.name = name;
      x.port = port;
      x.exp  = exp;
      exp_q.push_back(x);
   endtask

   task automatic park_reads();
      for (int p = 0; p < 4; p++) begin
         ra[p] = 32'd0;
         rm[p] = WORD;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (core_run !== 1'b0 || ld_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state: core_run=%b ld_ready=%b required 0/1", core_run, ld_ready);
      end else $display("ok   reset_state: core_run=0 ld_ready=1");
      checks++;
      if (err !== 1'b0 || err_addr !== 32'd0) begin
         failures++;
         $display("FAIL reset_err: err=%b err_addr=%08h required 0/00000000", err, err_addr);
      end else $display("ok   reset_err: err=0 err_addr=0");
      tick();
      reset = 1'b1;
   endtask

   task automatic test_load();
      logic [31:0] img [3];
      img[0] = 32'h0000_0093;
      img[1] = 32'h0010_0113;
      img[2] = 32'hDEAD_BEEF;
      for (int k = 0; k < 3; k++) begin
         ld_valid = 1'b1;
         ld_data  = img[k];
         ld_last  = (k == 2);
         if (k == 2) begin
            drive_read("load_rd_zero", 0, 32'd0, WORD, 32'd0);
            @(negedge clk);
            while (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checks++;
               if (rd[e.port] !== e.exp) begin
                  failures++;
                  $display("FAIL %s: rd[%0d]=%08h required %08h", e.name, e.port, rd[e.port], e.exp);
               end else $display("ok   %s: rd[%0d]=%08h", e.name, e.port, rd[e.port]);
            end
            checks++;
            if (core_run !== 1'b0) begin
               failures++;
               $display("FAIL load_not_run: core_run=%b required 0", core_run);
            end else $display("ok   load_not_run: core_run=0");
         end
         tick();
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      drive_read("load_word2", 0, 32'd8, WORD, 32'hDEAD_BEEF);
      drive_read("load_word0", 1, 32'd0, WORD, 32'h0000_0093);
      @(negedge clk);
      checks++;
      if (core_run !== 1'b1 || ld_ready !== 1'b0) begin
         failures++;
         $display("FAIL load_run: core_run=%b ld_ready=%b required 1/0", core_run, ld_ready);
      end else $display("ok   load_run: core_run=1 ld_ready=0");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rd[e.port] !== e.exp) begin
            failures++;
            $display("FAIL %s: rd[%0d]=%08h required %08h", e.name, e.port, rd[e.port], e.exp);
         end else $display("ok   %s: rd[%0d]=%08h", e.name, e.port, rd[e.port]);
      end
   endtask

   task automatic test_modes();
      tick();
      drive_read("byte_8",   0, 32'd8,  BYTE,  32'hFFFF_FFEF);
      drive_read("ubyte_11", 1, 32'd11, UBYTE, 32'h0000_00DE);
      drive_read("half_10",  2, 32'd10, HALF,  32'hFFFF_DEAD);
      drive_read("uhalf_8",  3, 32'd8,  UHALF, 32'h0000_BEEF);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rd[e.port] !== e.exp) begin
            failures++;
            $display("FAIL %s: rd[%0d]=%08h required %08h", e.name, e.port, rd[e.port], e.exp);
         end else $display("ok   %s: rd[%0d]=%08h", e.name, e.port, rd[e.port]);
      end
      tick();
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL modes_no_err: err=%b required 0", err);
      end else $display("ok   modes_no_err: err=0");
   endtask

   task automatic test_byte_store();
      park_reads();
      drive_read("store_same_cycle", 2, 32'd8,  WORD,  32'hDEAD_BEEF);
      drive_read("store_other_byte", 3, 32'd11, UBYTE, 32'h0000_00DE);
      we = 1'b1;
      wa = 32'd9;
      wd = 32'h1234_5678;
      wm = BYTE;
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rd[e.port] !== e.exp) begin
            failures++;
            $display("FAIL %s: rd[%0d]=%08h required %08h", e.name, e.port, rd[e.port], e.exp);
         end else $display("ok   %s: rd[%0d]=%08h", e.name, e.port, rd[e.port]);
      end
      tick();
      we = 1'b0;
      drive_read("store_next_cycle", 2, 32'd8, WORD, 32'hDEAD_78EF);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rd[e.port] !== e.exp) begin
            failures++;
            $display("FAIL %s: rd[%0d]=%08h required %08h", e.name, e.port, rd[e.port], e.exp);
         end else $display("ok   %s: rd[%0d]=%08h", e.name, e.port, rd[e.port]);
      end
   endtask

   task automatic test_misaligned();
      tick();
      park_reads();
      we = 1'b1;
      wa = 32'd6;
      wd = 32'hFFFF_FFFF;
      wm = WORD;
      @(negedge clk);
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL misalign_pre_err: err=%b required 0", err);
      end else $display("ok   misalign_pre_err: err=0");
      tick();
      we = 1'b0;
      drive_read("misalign_unchanged", 1, 32'd4, WORD, 32'h0010_0113);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rd[e.port] !== e.exp) begin
            failures++;
            $display("FAIL %s: rd[%0d]=%08h required %08h", e.name, e.port, rd[e.port], e.exp);
         end else $display("ok   %s: rd[%0d]=%08h", e.name, e.port, rd[e.port]);
      end
      checks++;
      if (err !== 1'b1 || err_addr !== 32'd6) begin
         failures++;
         $display("FAIL misalign_err: err=%b err_addr=%08h required 1/00000006", err, err_addr);
      end else $display("ok   misalign_err: err=1 err_addr=6");
      tick();
      drive_read("oor_read_zero", 3, 32'h0000_4002, HALF, 32'd0);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rd[e.port] !== e.exp) begin
            failures++;
            $display("FAIL %s: rd[%0d]=%08h required %08h", e.name, e.port, rd[e.port], e.exp);
         end else $display("ok   %s: rd[%0d]=%08h", e.name, e.port, rd[e.port]);
      end
      tick();
      park_reads();
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || err_addr !== 32'd6) begin
         failures++;
         $display("FAIL sticky_err_addr: err=%b err_addr=%08h required 1/00000006", err, err_addr);
      end else $display("ok   sticky_err_addr: err=1 err_addr=6");
   endtask

   task automatic test_overflow();
      s_reset = 1'b0;
      tick();
      s_reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         s_ld_valid = 1'b1;
         s_ld_data  = 32'(k + 1);
         s_ld_last  = 1'b0;
         if (k == 4) begin
            @(negedge clk);
            checks++;
            if (s_err !== 1'b0) begin
               failures++;
               $display("FAIL ovf_pre_err: err=%b required 0", s_err);
            end else $display("ok   ovf_pre_err: err=0");
         end
         tick();
      end
      s_ld_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (s_err !== 1'b1 || s_err_addr !== 32'd16) begin
         failures++;
         $display("FAIL ovf_err: err=%b err_addr=%08h required 1/00000010", s_err, s_err_addr);
      end else $display("ok   ovf_err: err=1 err_addr=10");
      checks++;
      if (s_core_run !== 1'b0 || s_ld_ready !== 1'b1) begin
         failures++;
         $display("FAIL ovf_state: core_run=%b ld_ready=%b required 0/1", s_core_run, s_ld_ready);
      end else $display("ok   ovf_state: core_run=0 ld_ready=1");
      s_ld_valid = 1'b1;
      s_ld_last  = 1'b1;
      s_ld_data  = 32'hFFFF_0000;
      tick();
      s_ld_valid = 1'b0;
      s_ld_last  = 1'b0;
      @(negedge clk);
      checks++;
      if (s_core_run !== 1'b0) begin
         failures++;
         $display("FAIL ovf_last_dropped: core_run=%b required 0", s_core_run);
      end else $display("ok   ovf_last_dropped: core_run=0");
   endtask

   task automatic test_reset_midload();
      park_reads();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         ld_valid = 1'b1;
         ld_data  = 32'hAAAA_0001 + 32'(k);
         ld_last  = 1'b0;
         tick();
      end
      ld_valid = 1'b0;
      reset    = 1'b0;
      tick();
      reset    = 1'b1;
      ld_valid = 1'b1;
      ld_data  = 32'hBBBB_0003;
      ld_last  = 1'b1;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      drive_read("midload_word0", 0, 32'd0, WORD, 32'hBBBB_0003);
      drive_read("midload_word1", 1, 32'd4, WORD, 32'hAAAA_0002);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rd[e.port] !== e.exp) begin
            failures++;
            $display("FAIL %s: rd[%0d]=%08h required %08h", e.name, e.port, rd[e.port], e.exp);
         end else $display("ok   %s: rd[%0d]=%08h", e.name, e.port, rd[e.port]);
      end
      checks++;
      if (err !== 1'b0 || core_run !== 1'b1) begin
         failures++;
         $display("FAIL midload_state: err=%b core_run=%b required 0/1", err, core_run);
      end else $display("ok   midload_state: err=0 core_run=1");
   endtask

   initial begin
      reset      = 1'b0;
      s_reset    = 1'b0;
      we         = 1'b0;
      wa         = 32'd0;
      wd         = 32'd0;
      wm         = WORD;
      ld_valid   = 1'b0;
      ld_data    = 32'd0;
      ld_last    = 1'b0;
      s_ld_valid = 1'b0;
      s_ld_data  = 32'd0;
      s_ld_last  = 1'b0;
      park_reads();

      test_reset();
      test_load();
      test_modes();
      test_byte_store();
      test_misaligned();
      test_overflow();
      test_reset_midload();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memory_responder.md
# memory_responder

Target side of the core's memory bus: a unified instruction/data RAM with four combinational read ports (two fetch, two load) and one synchronous store port, honouring the `ldst_mode` access widths. A boot-load FSM streams a program image into the RAM after reset and holds the core stopped (`core_run` low) until loading completes. Misaligned, out-of-range and loader-overflow accesses set a sticky error flag.

## Interface
- `DEPTH`, 4096: storage size in 32-bit words; power of two.
- `clk  input  1`: sole clock; all state updates on its rising edge.
- `reset  input  1`: synchronous, active-low reset.
- `ra[4]  input  32`: read byte addresses; [0],[1] fetch, [2],[3] load.
- `rm[4]  input  ldst_mode`: read access mode per port.
- `rd[4]  output  32`: read data per port, combinational.
- `we  input  1`: store enable.
- `wa  input  32`: store byte address.
- `wd  input  32`: store data, right-aligned.
- `wm  input  ldst_mode`: store mode; only BYTE/HALF/WORD are meaningful.
- `ld_valid  input  1`: loader word valid.
- `ld_data  input  32`: loader word.
- `ld_last  input  1`: qualifies final loader word.
- `ld_ready  output  1`: loader may transfer; high only in LOAD.
- `core_run  output  1`: core may leave reset; high only in RUN.
- `err  output  1`: sticky error flag.
- `err_addr  output  32`: address of the first error.

## Operation
- Address decode: word index = `addr[2+log2(DEPTH)-1:2]`. Out of range when `addr >= 4*DEPTH`.
- Alignment: HALF/UHALF need `addr[0]==0`. WORD needs `addr[1:0]==0`.
- Read, per port, independent:
  - Select byte lane `addr[1:0]` (BYTE/UBYTE) or half lane `addr[1]` (HALF/UHALF).
  - BYTE/HALF sign-extend; UBYTE/UHALF zero-extend; WORD returns the full word.
  - Little-endian.
  - A misaligned or out-of-range read returns 0.
- Write, on a clock edge with `we` high in RUN: update only the bytes covered by `wm`, taking them from the low bits of `wd`.
  - A misaligned or out-of-range write is dropped.
  - A write with `wm` of UBYTE/UHALF is treated as BYTE/HALF.
- Errors:
  - Any misaligned or out-of-range access in RUN sets `err`: a read on a port whose address is in use, or a write with `we` high.
  - `err_addr` latches the offending address only when `err` was 0.
  - Priority for simultaneous errors: write, then `ra[0]` → `ra[3]`.
- FSM states:
  - LOAD: `ld_ready`=1. Each cycle with `ld_valid` high writes `ld_data` to word `ptr`, then `ptr++`. When `ld_last` is accepted → RUN. If a valid word arrives with `ptr==DEPTH`: word dropped, `err`=1, `err_addr`=`4*DEPTH`, state stays LOAD.
  - RUN: `core_run`=1. Bus writes are honoured. Loader input is ignored. Stays in RUN until reset.
- In LOAD, bus writes are ignored and all `rd` are 0.
- Reads in LOAD raise no error.

## Timing
- Reset (reset low at a clock edge): state=LOAD, `ptr`=0, `err`=0, `err_addr`=0, `core_run`=0, `ld_ready`=1.
- RAM contents are not cleared by reset.
- Reset asserted mid-load restarts the load at word 0.
- `rd` is combinational from `ra`/`rm` and the current array contents: zero-cycle read latency.
- A store is visible to reads the cycle after its edge. A read of the same address in the store's own cycle returns the old data; no forwarding.
- Loader handshake: a transfer occurs when `ld_valid && ld_ready` at an edge.
- The edge accepting `ld_last` moves the FSM to RUN, so `core_run` is 1 in the next cycle and the last word is readable then.
- A store and a read of different bytes in the same word in the same cycle are both correct.

## Structure
- Shared package holds:
  - The `ldst_mode` enum (BYTE, HALF, WORD, UBYTE, UHALF), already used by the core.
  - A `mem_state` enum (LOAD, RUN).
- Sub-module `mem_read_lane`:
  - Inputs: one address, one mode, one word.
  - Outputs: extracted/extended data and `misaligned`.
  - Instantiated four times.
- The storage array, byte-masked write, FSM, pointer and error logic live in the top module.

## Test plan
- Load: stream 0x00000093, 0x00100113, 0xDEADBEEF with `ld_last` on the third word. Required:
  - `core_run` rises one cycle after that edge.
  - `ra[0]`=8, WORD → 0xDEADBEEF.
  - `ra[1]`=0, WORD → 0x00000093.
- Mode extraction, word 2 = 0xDEADBEEF:
  - BYTE@8 → 0xFFFFFFEF.
  - UBYTE@11 → 0x000000DE.
  - HALF@10 → 0xFFFFDEAD.
  - UHALF@8 → 0x0000BEEF.
- Byte store: `we`=1, `wa`=9, `wd`=0x12345678, `wm`=BYTE. Required:
  - Same-cycle read@8 WORD → 0xDEADBEEF.
  - Next cycle → 0xDEAD78EF.
- Misaligned: WORD store to `wa`=6. Required:
  - Memory unchanged.
  - `err`=1, `err_addr`=6.
  - A later bad read@0x4002 with HALF leaves `err_addr`=6.
- Overflow: with `DEPTH`=4, stream 5 words without `ld_last`. Required:
  - 5th word dropped.
  - `err`=1, `err_addr`=16, `core_run`=0.
- Reset mid-load: after 2 words, assert reset (low) for one edge, then stream 1 word with `ld_last`. Required:
  - Word 0 holds the new value.
  - Word 1 keeps its old value.
  - `err`=0, `core_run`=1.
